// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution unit.
// Optional feature macro used by cond_unit: COND_PERF_EN.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code decode against the architectural {N,Z,C,V}.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_t'(cond))
            EQ: pass = w_z;
            NE: pass = !w_z;
            CS: pass = w_c;
            CC: pass = !w_c;
            MI: pass = w_n;
            PL: pass = !w_n;
            VS: pass = w_v;
            VC: pass = !w_v;
            HI: pass = w_c & !w_z;
            LS: pass = !w_c | w_z;
            GE: pass = (w_n == w_v);
            LT: pass = (w_n != w_v);
            GT: pass = !w_z & (w_n == w_v);
            LE: pass = w_z | (w_n != w_v);
            AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: gates decoder write enables by the condition and owns the flags.
// Define COND_PERF_EN to add saturating exec/skip instruction counters.
module cond_unit
    import cond_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pc_s,
    input  logic       reg_w,
    input  logic       mem_w,
    output logic       valid_o,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex_o,
    output logic       undef_o,
    output logic [3:0] flags_o
`ifdef COND_PERF_EN
    ,
    output logic [15:0] exec_cnt,
    output logic [15:0] skip_cnt
`endif
);

    logic [3:0] r_flags;
    logic       w_pass;
    logic       w_exec;

    cond_check u_cond_check (
        .cond  (cond),
        .flags (r_flags),
        .pass  (w_pass)
    );

    assign w_exec  = valid_i & w_pass;
    assign flags_o = r_flags;

    // Flags update on the same edge as the outputs, so the next instruction sees them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags   <= 4'b0000;
            valid_o   <= 1'b0;
            pc_src    <= 1'b0;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
            cond_ex_o <= 1'b0;
            undef_o   <= 1'b0;
        end else begin
            if (w_exec && flag_w[1]) begin
                r_flags[FLAG_N] <= alu_flags[FLAG_N];
                r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (w_exec && flag_w[0]) begin
                r_flags[FLAG_C] <= alu_flags[FLAG_C];
                r_flags[FLAG_V] <= alu_flags[FLAG_V];
            end
            valid_o   <= valid_i;
            pc_src    <= pc_s & w_exec;
            reg_write <= reg_w & w_exec;
            mem_write <= mem_w & w_exec;
            cond_ex_o <= w_exec;
            undef_o   <= valid_i & (cond == 4'(NV));
        end
    end

`ifdef COND_PERF_EN
    logic [15:0] r_exec_cnt;
    logic [15:0] r_skip_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else if (valid_i) begin
            if (w_pass && r_exec_cnt != CNT_MAX)
                r_exec_cnt <= r_exec_cnt + 16'd1;
            if (!w_pass && r_skip_cnt != CNT_MAX)
                r_skip_cnt <= r_skip_cnt + 16'd1;
        end
    end

    assign exec_cnt = r_exec_cnt;
    assign skip_cnt = r_skip_cnt;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pc_s, reg_w, mem_w;
    logic       valid_o, pc_src, reg_write, mem_write, cond_ex_o, undef_o;
    logic [3:0] flags_o;
`ifdef COND_PERF_EN
    logic [15:0] exec_cnt, skip_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    bit [3:0] m_flags;
    int       m_exec, m_skip;

    cond_unit dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_w    (flag_w),
        .pc_s      (pc_s),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .valid_o   (valid_o),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .cond_ex_o (cond_ex_o),
        .undef_o   (undef_o),
        .flags_o   (flags_o)
`ifdef COND_PERF_EN
        ,
        .exec_cnt  (exec_cnt),
        .skip_cnt  (skip_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ARM condition semantics written as a truth table over named flag values
    function automatic bit ref_pass(input int c, input bit [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cy;
            3:  return !cy;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cy && !z;
            9:  return !cy || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Apply one cycle of stimulus, clock it, then compare every output to the model.
    task automatic step(input bit rst, input bit vld, input int c, input bit [3:0] af,
                        input bit [1:0] fw, input bit ps, input bit rw, input bit mw,
                        input string tag);
        bit p, ex;
        bit [6:0] exp_o;
        reset = rst; valid_i = vld; cond = 4'(c); alu_flags = af;
        flag_w = fw; pc_s = ps; reg_w = rw; mem_w = mw;
        @(posedge clk);
        #1;
        p  = ref_pass(c, m_flags);
        ex = vld && p && !rst;
        if (rst) begin
            m_flags = 4'b0000;
            exp_o   = 7'b0;
            m_exec  = 0;
            m_skip  = 0;
        end else begin
            exp_o = {vld, ex, ps && ex, rw && ex, mw && ex, 1'b0, vld && c == 15};
            if (ex && fw[1]) m_flags[3:2] = af[3:2];
            if (ex && fw[0]) m_flags[1:0] = af[1:0];
            if (vld && p && m_exec < 65535) m_exec++;
            if (vld && !p && m_skip < 65535) m_skip++;
        end
        chk({tag, ".outs"}, {25'b0, valid_o, cond_ex_o, pc_src, reg_write, mem_write, 1'b0, undef_o},
            {25'b0, exp_o});
        chk({tag, ".flags"}, {28'b0, flags_o}, {28'b0, m_flags});
`ifdef COND_PERF_EN
        chk({tag, ".exec"}, {16'b0, exec_cnt}, 32'(m_exec));
        chk({tag, ".skip"}, {16'b0, skip_cnt}, 32'(m_skip));
`endif
    endtask

    task automatic idle(input string tag);
        step(0, 0, 14, 4'h0, 2'b00, 0, 0, 0, tag);
    endtask

    // Load the flags register with an AL flag-setting instruction.
    task automatic setf(input bit [3:0] f, input string tag);
        step(0, 1, 14, f, 2'b11, 0, 0, 0, tag);
    endtask

    initial begin
        m_flags = '0; m_exec = 0; m_skip = 0;
        reset = 1'b1; valid_i = 0; cond = 0; alu_flags = 0; flag_w = 0;
        pc_s = 0; reg_w = 0; mem_w = 0;

        step(1, 0, 0, 4'h0, 2'b00, 0, 0, 0, "reset");
        chk("reset.flags_const", {28'b0, flags_o}, 32'h0);

        // AL reg write with flag set
        step(0, 1, 14, 4'b0100, 2'b11, 0, 1, 0, "al_write");
        chk("al_write.reg_write", {31'b0, reg_write}, 32'h1);
        chk("al_write.flags_o", {28'b0, flags_o}, 32'h4);

        // EQ passes, NE fails with Z set
        step(0, 1, 0, 4'h0, 2'b00, 0, 0, 1, "eq");
        chk("eq.mem_write", {31'b0, mem_write}, 32'h1);
        step(0, 1, 1, 4'h0, 2'b00, 0, 0, 1, "ne");
        chk("ne.mem_write", {31'b0, mem_write}, 32'h0);

        // GE fails with N!=V; flags must hold
        setf(4'b1000, "setf_n");
        step(0, 1, 10, 4'b0000, 2'b11, 0, 0, 0, "ge_fail");
        chk("ge_fail.flags_o", {28'b0, flags_o}, 32'h8);
        chk("ge_fail.cond_ex_o", {31'b0, cond_ex_o}, 32'h0);

        // Back-to-back CMP then HI
        step(0, 1, 14, 4'b0110, 2'b11, 0, 0, 0, "cmp_z");
        step(0, 1, 8, 4'h0, 2'b00, 1, 0, 0, "hi_z");
        chk("hi_z.pc_src", {31'b0, pc_src}, 32'h0);
        step(0, 1, 14, 4'b0010, 2'b11, 0, 0, 0, "cmp_c");
        step(0, 1, 8, 4'h0, 2'b00, 1, 0, 0, "hi_c");
        chk("hi_c.pc_src", {31'b0, pc_src}, 32'h1);

        // Partial flag writes
        step(0, 1, 14, 4'b1111, 2'b10, 0, 0, 0, "fw_nz");
        step(0, 1, 14, 4'b0000, 2'b01, 0, 0, 0, "fw_cv");
        chk("fw_cv.flags_o", {28'b0, flags_o}, 32'hC);

        // NV undefined, then reset with a valid instruction presented
        step(0, 1, 15, 4'hF, 2'b11, 1, 1, 1, "nv");
        chk("nv.undef_o", {31'b0, undef_o}, 32'h1);
        chk("nv.reg_write", {31'b0, reg_write}, 32'h0);
        step(1, 1, 14, 4'hF, 2'b11, 1, 1, 1, "rst_valid");
        chk("rst_valid.flags_o", {28'b0, flags_o}, 32'h0);
        idle("idle");

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 3) != 0, $urandom_range(0, 15),
                 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

`ifdef COND_PERF_EN
        step(1, 0, 0, 4'h0, 2'b00, 0, 0, 0, "perf_rst");
        reset = 0; valid_i = 1; cond = 4'd14; flag_w = 0; pc_s = 0; reg_w = 0; mem_w = 0;
        repeat (70000) @(posedge clk);
        #1;
        chk("perf.exec_cnt", {16'b0, exec_cnt}, 32'hFFFF);
        chk("perf.skip_cnt", {16'b0, skip_cnt}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
